// File: rtl/bitrev_reorder_pkg.sv
// Shared types for the bit-reversal reorder buffer: bank occupancy flags
// and the reader state machine encoding.
package bitrev_reorder_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } bank_flag_t;

   typedef enum logic {
      RD_IDLE   = 1'b0,
      RD_STREAM = 1'b1
   } rd_state_t;

endpackage

// File: rtl/reverse_vector.sv
// Bit-reversal of a vector: bit i of the result is bit WIDTH-1-i of the input.
// Pure wiring, no logic depth.
module reverse_vector #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] vec,
   output logic [WIDTH-1:0] rev
);

   // Mirror the bit order of the input vector.
   always_comb begin
      rev = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rev[i] = vec[WIDTH-1-i];
      end
   end

endmodule

// File: rtl/bitrev_reorder.sv
// Streaming reorder buffer: frames of 2^ADDR_W samples arrive in natural
// order and leave in bit-reversed index order. Two ping-pong banks let one
// frame fill while the other drains, giving one sample per clock sustained.
module bitrev_reorder
   import bitrev_reorder_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   localparam int                N        = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

   // Sample storage; intentionally not reset so it maps onto distributed RAM.
   logic [DATA_W-1:0] mem [2][N];

   bank_flag_t        flag [2];
   logic              wsel;
   logic [ADDR_W-1:0] wcnt;
   logic              rsel;
   logic              rsel_other;
   logic [ADDR_W-1:0] rcnt;
   logic [ADDR_W-1:0] raddr;
   rd_state_t         state;
   rd_state_t         state_nxt;

   logic wr_en;
   logic wr_done;
   logic rd_avail;
   logic rd_load;
   logic rd_done;

   reverse_vector #(
      .WIDTH (ADDR_W)
   ) u_rev (
      .vec (rcnt),
      .rev (raddr)
   );

   // Handshake qualifiers. The reader may load in the very cycle a bank
   // becomes FULL so the first word leaves N+1 cycles after it arrived.
   always_comb begin
      in_ready   = (flag[wsel] == EMPTY);
      wr_en      = in_valid && in_ready;
      wr_done    = wr_en && (wcnt == CNT_LAST);
      rsel_other = ~rsel;
      rd_avail   = (state == RD_STREAM) || (flag[rsel] == FULL);
      rd_load    = rd_avail && (!out_valid || out_ready);
      rd_done    = rd_load && (rcnt == CNT_LAST);
   end

   // Reader next-state: stay streaming across a bank switch when the other
   // bank is already full, so back-to-back frames have no bubble.
   always_comb begin
      state_nxt = state;
      case (state)
         RD_IDLE: begin
            if (flag[rsel] == FULL) begin
               state_nxt = RD_STREAM;
            end else begin
               state_nxt = RD_IDLE;
            end
         end
         RD_STREAM: begin
            if (rd_done) begin
               state_nxt = (flag[rsel_other] == FULL) ? RD_STREAM : RD_IDLE;
            end else begin
               state_nxt = RD_STREAM;
            end
         end
         default: state_nxt = RD_IDLE;
      endcase
   end

   // Reader state register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= RD_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Write pointer: advance per accepted sample, switch bank after the last.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wcnt <= '0;
         wsel <= 1'b0;
      end else if (wr_en) begin
         wcnt <= wcnt + CNT_ONE;
         if (wr_done) begin
            wsel <= ~wsel;
         end
      end
   end

   // Bank flags: only the writer sets, only the reader clears; the two never
   // address the same bank in one cycle.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         flag[0] <= EMPTY;
         flag[1] <= EMPTY;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (wr_done && (wsel == 1'(b))) begin
               flag[b] <= FULL;
            end else if (rd_done && (rsel == 1'(b))) begin
               flag[b] <= EMPTY;
            end else begin
               flag[b] <= flag[b];
            end
         end
      end
   end

   // Sample write into the bank being filled.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wsel][wcnt] <= in_data;
      end
   end

   // Read pointer: advance per output load, switch bank after the last.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rcnt <= '0;
         rsel <= 1'b0;
      end else if (rd_load) begin
         rcnt <= rcnt + CNT_ONE;
         if (rd_done) begin
            rsel <= ~rsel;
         end
      end
   end

   // Output register: loads bit-reversed samples, holds under back-pressure.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (rd_load) begin
         out_data  <= mem[rsel][raddr];
         out_valid <= 1'b1;
         out_last  <= (rcnt == CNT_LAST);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bitrev_reorder.sv
// Scoreboard bench for bitrev_reorder: a model captures accepted samples,
// and each completed frame pushes its bit-reversed sequence into a queue
// that a separate monitor pops at every output handshake.
module tb_bitrev_reorder;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int N  = 16;
   localparam int T1 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
   localparam int T6 [4]  = '{0, 2, 1, 3};

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;

   logic [DW-1:0] s_in_data = '0;
   logic          s_in_valid = 1'b0;
   logic          s_in_ready;
   logic [DW-1:0] s_out_data;
   logic          s_out_valid;
   logic          s_out_ready = 1'b1;
   logic          s_out_last;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int nready_miss = 0;

   exp_t          exp_q [$];
   logic [DW-1:0] frame_buf [$];
   int            hs_cyc [$];
   int            t1_q [$];
   exp_t          s_got [$];
   exp_t          mon_e;

   bit            track = 1'b0;
   bit            rec1 = 1'b0;
   int            first_acc_cyc = -1;
   int            first_ov_cyc = -1;
   bit            hold_prev = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   bitrev_reorder #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   bitrev_reorder #(.DATA_W(DW), .ADDR_W(2)) dut_small (
      .clk       (clk),
      .nrst      (nrst),
      .in_data   (s_in_data),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .out_data  (s_out_data),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_last  (s_out_last)
   );

   // Index whose binary digits are those of i read backwards (w digits).
   function automatic int bitrev(input int i, input int w);
      int r = 0;
      for (int b = 0; b < w; b++) begin
         if (((i / (1 << b)) % 2) == 1) r += 1 << (w - 1 - b);
      end
      return r;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: collect accepted samples, emit a reordered frame when full.
   always @(negedge clk) begin
      if (!nrst) begin
         frame_buf.delete();
      end else if (in_valid && in_ready) begin
         if (track && first_acc_cyc < 0) first_acc_cyc = cyc;
         frame_buf.push_back(in_data);
         if (frame_buf.size() == N) begin
            for (int k = 0; k < N; k++) begin
               exp_q.push_back('{data: frame_buf[bitrev(k, AW)], last: (k == N - 1)});
            end
            frame_buf.delete();
         end
      end
   end

   // Monitor: compare every output handshake, and check stability under stall.
   always @(negedge clk) begin
      if (!nrst) begin
         hold_prev = 1'b0;
      end else begin
         if (track && first_ov_cyc < 0 && out_valid) first_ov_cyc = cyc;
         if (hold_prev) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_data", int'(out_data), int'(prev_data));
            check("stall_last", int'(out_last), int'(prev_last));
         end
         if (out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (rec1) t1_q.push_back(int'(out_data));
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out: got data %0d, expected no output", out_data);
            end else begin
               mon_e = exp_q.pop_front();
               check("out_data", int'(out_data), int'(mon_e.data));
               check("out_last", int'(out_last), int'(mon_e.last));
            end
         end
         hold_prev = out_valid && !out_ready;
         prev_data = out_data;
         prev_last = out_last;
      end
   end

   // Collector for the minimum-size instance.
   always @(negedge clk) begin
      if (nrst && s_out_valid && s_out_ready) s_got.push_back('{data: s_out_data, last: s_out_last});
   end

   // Drive samples base+i (or random) with random valid/ready until count accepted.
   task automatic feed(input int count, input int base, input bit rnd, input int vpct,
                       input int rpct, input int budget);
      int sent = 0;
      int n = 0;
      bit acc;
      while (sent < count && n < budget) begin
         in_valid  = ($urandom_range(99) < vpct);
         in_data   = rnd ? DW'($urandom) : DW'(base + sent);
         out_ready = ($urandom_range(99) < rpct);
         @(negedge clk);
         if (in_valid && !in_ready) nready_miss++;
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) sent++;
         n++;
      end
      in_valid = 1'b0;
      check("feed_accepted", sent, count);
   endtask

   // Let the scoreboard empty, within a cycle budget.
   task automatic drain(input int rpct, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         out_ready = ($urandom_range(99) < rpct);
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_left", exp_q.size(), 0);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 nrst = 1'b1;
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_last", int'(out_last), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;

      // 1: single frame, latency and literal order
      track = 1'b1;
      rec1  = 1'b1;
      feed(16, 0, 1'b0, 100, 100, 100);
      drain(100, 100);
      track = 1'b0;
      rec1  = 1'b0;
      check("latency_first_valid", first_ov_cyc - first_acc_cyc, N + 1);
      check("t1_count", t1_q.size(), 16);
      for (int i = 0; i < 16 && i < t1_q.size(); i++) check("t1_order", t1_q[i], T1[i]);

      // 2: three back-to-back frames, no input stall, no output gaps
      hs_cyc.delete();
      nready_miss = 0;
      feed(48, 0, 1'b0, 100, 100, 200);
      drain(100, 200);
      check("stream_in_ready_drops", nready_miss, 0);
      check("stream_out_count", hs_cyc.size(), 48);
      if (hs_cyc.size() == 48) check("stream_out_span", hs_cyc[47] - hs_cyc[0], 47);

      // 3: full back-pressure
      feed(32, 0, 1'b0, 100, 0, 100);
      in_valid = 1'b1;
      in_data  = DW'(999);
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", int'(in_ready), 0);
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_out_data", int'(out_data), 0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      drain(100, 200);

      // 4: random stalls, 20 frames of random data
      feed(20 * N, 0, 1'b1, 70, 60, 20000);
      drain(60, 5000);

      // 5: reset after frame 1 plus 7 samples of frame 2
      feed(23, 0, 1'b1, 100, 0, 100);
      nrst = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
      @(negedge clk);
      check("rst2_out_valid", int'(out_valid), 0);
      check("rst2_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
      rec1 = 1'b1;
      t1_q.delete();
      feed(16, 100, 1'b0, 100, 100, 100);
      drain(100, 100);
      rec1 = 1'b0;
      if (t1_q.size() >= 3) begin
         check("rst2_first", t1_q[0], 100);
         check("rst2_second", t1_q[1], 108);
         check("rst2_third", t1_q[2], 104);
      end else begin
         check("rst2_count", t1_q.size(), 16);
      end

      // 6: minimum frame size on the ADDR_W = 2 instance
      for (int i = 0; i < 4; i++) begin
         s_in_valid = 1'b1;
         s_in_data  = DW'(i);
         @(negedge clk);
         check("small_in_ready", int'(s_in_ready), 1);
         @(posedge clk);
         #1;
      end
      s_in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("small_count", s_got.size(), 4);
      for (int i = 0; i < 4 && i < s_got.size(); i++) begin
         check("small_data", int'(s_got[i].data), T6[i]);
         check("small_last", int'(s_got[i].last), (i == 3) ? 1 : 0);
      end

      check("leftover_expected", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bitrev_reorder.md
# bitrev_reorder

Streaming reorder buffer that accepts frames of 2^ADDR_W samples in natural order and emits each frame in bit-reversed index order, as needed at FFT/IFFT input or output boundaries. Two ping-pong memory banks let one frame be written while the previous one drains, so sustained throughput is one sample per clock. Read addressing passes through the team's reverse_vector bit-reversal block. Both sides use valid/ready handshakes.

## Interface
- DATA_W, 16, sample width in bits.
- ADDR_W, 4, log2 of the frame length, so frame length N = 2^ADDR_W. ADDR_W must be at least 2.
- clk  input  1  single clock, rising edge.
- nrst  input  1  reset, asynchronous and active-low.
- in_data  input  DATA_W  input sample, in natural-order index.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample. Combinational from the write-bank state.
- out_data  output  DATA_W  output sample (registered).
- out_valid  output  1  out_data is valid (registered).
- out_ready  input  1  downstream accepts the output sample.
- out_last  output  1  marks the final sample of a frame (registered, qualified by out_valid).

## Operation
- **Storage.** Memory is mem[2][N] × DATA_W. Memory contents are not reset.
- **Bank flags.** Each bank has a flag, EMPTY or FULL.
- **Write side.**
  - Write pointers: wsel (1 bit) and wcnt (ADDR_W bits).
  - in_ready = (flag[wsel] == EMPTY).
  - On each accepted sample (in_valid & in_ready): mem[wsel][wcnt] ← in_data and wcnt++.
  - When wcnt == N−1 is accepted: wcnt wraps to 0, flag[wsel] ← FULL, and wsel toggles.
- **Read side.**
  - Read pointers: rsel (1 bit) and rcnt (ADDR_W bits).
  - raddr = bitrev(rcnt), produced by reverse_vector with WIDTH = ADDR_W.
- **Reader FSM.**
  - RD_IDLE: go to RD_STREAM when flag[rsel] == FULL.
  - RD_STREAM: the output register loads when (!out_valid | out_ready). Each load sets out_data ← mem[rsel][raddr], out_valid ← 1, out_last ← (rcnt == N−1), and rcnt++.
  - On the load with rcnt == N−1: flag[rsel] ← EMPTY, rsel toggles, and the FSM returns to RD_IDLE. If the other bank is already FULL, the FSM stays in RD_STREAM with no bubble.
  - When no load occurs and out_ready = 1, out_valid ← 0.
- **Flag ownership.** A bank's flag is set only by the writer and cleared only by the reader. The writer and reader never touch the same bank in the same cycle.
- **Back-pressure.** While out_valid = 1 and out_ready = 0, out_data and out_last hold stable. When both banks are FULL, in_ready = 0.
- **Reset.**
  - On reset: flags EMPTY, wsel = rsel = 0, wcnt = rcnt = 0, FSM in RD_IDLE, out_valid = 0, out_last = 0, out_data = 0.
  - As a result, in_ready = 1 out of reset.
  - Reset mid-frame discards all partial and full frames. The next accepted sample is index 0 of bank 0.

## Timing
- **Latency.** For a frame whose first sample is accepted at cycle t with no stalls:
  - Last write is at t+N−1, and FULL is visible at t+N.
  - First output load is at t+N, so out_valid = 1 from t+N+1.
  - out_data for sample 0 appears N+1 cycles after it is accepted.
- **Throughput.** With in_valid = out_ready = 1 continuously, the current read bank is released at the edge ending cycle t+2N−1, just as the writer wraps to it. in_ready therefore never deasserts and the output has no bubbles after the first word.
- **Release timing.** A bank released by the reader's last load is visible as EMPTY (in_ready = 1) on the next cycle.
- **Arithmetic.** Counters are ADDR_W bits and wrap naturally. No other arithmetic is performed.

## Structure
- **Package bitrev_reorder_pkg:**
  - bank_flag_t enum {EMPTY, FULL};
  - rd_state_t enum {RD_IDLE, RD_STREAM}.
- **Module-local:** N is a localparam derived from ADDR_W.
- **Sub-module:** one instance of reverse_vector (WIDTH = ADDR_W) mapping rcnt to raddr.
- **Memory:** a plain reg array, read combinationally into the output register. It is suitable for distributed RAM.

## Test plan
All scenarios use DATA_W = 16 and ADDR_W = 4 unless stated.
1. **Single frame.** in_data 0..15 with out_ready = 1 → outputs 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. out_last = 1 only on 15. First out_valid appears 17 cycles after the first accept.
2. **Continuous streaming.** Three back-to-back frames (0..47) with out_ready = 1 → in_ready stays 1 throughout. 48 consecutive output valids with no gaps, each frame bit-reversed (frame 2 starts 16, 24, 20…).
3. **Full back-pressure.** out_ready = 0 throughout → 32 samples accepted, then in_ready = 0 at the 33rd. out_valid = 1 with out_data = 0 held stable. Releasing out_ready drains the frames in order.
4. **Random stalls.** Random in_valid and out_ready, 20 frames → scoreboard exact match, no loss or duplication. out_data is stable whenever stalled.
5. **Reset mid-frame.** nrst pulsed after 7 samples of frame 2 → out_valid = 0 and in_ready = 1 after reset. A new frame 100..115 outputs 100, 108, 104, …, 115.
6. **Minimum size.** ADDR_W = 2, inputs 0..3 → outputs 0, 2, 1, 3, with out_last on 3.
